// File: rtl/xalu_hilo_pkg.sv
// Shared op codes, default latencies and FSM state type for the HI/LO multiply/divide unit.
// Optional accumulate ops are enabled by defining XALU_MADD_EN.
package xalu_hilo_pkg;

    localparam int unsigned XaluOpSize = 4;

    localparam logic [XaluOpSize-1:0] XALU_NONE  = 4'd0;
    localparam logic [XaluOpSize-1:0] XALU_MULT  = 4'd1;
    localparam logic [XaluOpSize-1:0] XALU_MULTU = 4'd2;
    localparam logic [XaluOpSize-1:0] XALU_DIV   = 4'd3;
    localparam logic [XaluOpSize-1:0] XALU_DIVU  = 4'd4;
    localparam logic [XaluOpSize-1:0] XALU_MTHI  = 4'd5;
    localparam logic [XaluOpSize-1:0] XALU_MTLO  = 4'd6;
    localparam logic [XaluOpSize-1:0] XALU_MADD  = 4'd7;
    localparam logic [XaluOpSize-1:0] XALU_MADDU = 4'd8;
    localparam logic [XaluOpSize-1:0] XALU_MSUB  = 4'd9;
    localparam logic [XaluOpSize-1:0] XALU_MSUBU = 4'd10;

    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

`ifdef XALU_MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StRun} xalu_state_e;

    // Accumulate ops count as multiply-class only when the feature is built in.
    function automatic logic is_mul_op(input logic [XaluOpSize-1:0] op);
        return (op == XALU_MULT) || (op == XALU_MULTU) ||
               (MaddEn && ((op == XALU_MADD) || (op == XALU_MADDU) ||
                           (op == XALU_MSUB) || (op == XALU_MSUBU)));
    endfunction

    function automatic logic is_div_op(input logic [XaluOpSize-1:0] op);
        return (op == XALU_DIV) || (op == XALU_DIVU);
    endfunction

endpackage

// File: rtl/xalu_core.sv
// Combinational datapath: next {HI,LO} for a latched op and operands, plus divide-by-zero flag.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are present only when XALU_MADD_EN is defined.
module xalu_core
    import xalu_hilo_pkg::*;
(
    input  logic [XaluOpSize-1:0] op,
    input  logic [31:0]           a,
    input  logic [31:0]           b,
    input  logic [31:0]           hi,
    input  logic [31:0]           lo,
    output logic [63:0]           result,
    output logic                  div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] hilo;
    logic [31:0] b_safe;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign hilo   = {hi, lo};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Substitute a divisor of 1 on zero so the dividers never see /0; the result is discarded.
    assign b_safe   = (b == 32'd0) ? 32'd1 : b;
    assign div_zero = is_div_op(op) && (b == 32'd0);

    // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    assign abs_a = a[31] ? (32'd0 - a) : a;
    assign abs_b = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    assign q_mag = abs_a / abs_b;
    assign r_mag = abs_a % abs_b;
    assign q_s   = (a[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = a / b_safe;
    assign r_u   = a % b_safe;

    always_comb begin
        result = hilo;
        case (op)
            XALU_NONE:  result = hilo;
            XALU_MULT:  result = prod_s;
            XALU_MULTU: result = prod_u;
            XALU_DIV:   result = {r_s, q_s};
            XALU_DIVU:  result = {r_u, q_u};
`ifdef XALU_MADD_EN
            XALU_MADD:  result = hilo + prod_s;
            XALU_MADDU: result = hilo + prod_u;
            XALU_MSUB:  result = hilo - prod_s;
            XALU_MSUBU: result = hilo - prod_u;
`endif
            default:    result = hilo;
        endcase
    end

endmodule

// File: rtl/xalu_hilo.sv
// E-stage multiply/divide unit owning the HI/LO registers; Busy stalls the pipe while an op runs.
// Define XALU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module xalu_hilo
    import xalu_hilo_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [XaluOpSize-1:0] XaluOp,
    input  logic [31:0]           A,
    input  logic [31:0]           B,
    output logic                  Busy,
    output logic [31:0]           HI,
    output logic [31:0]           LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    xalu_state_e           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [XaluOpSize-1:0] op_q, op_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           b_q, b_d;
    logic [31:0]           hi_q, hi_d;
    logic [31:0]           lo_q, lo_d;

    logic [63:0] result;
    logic        div_zero;

    // Accumulate ops read HI/LO live, so the sum reflects their value at the commit edge.
    xalu_core u_core (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .hi       (hi_q),
        .lo       (lo_q),
        .result   (result),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                // Move-to ops take priority over Start since they share the op field.
                if (XaluOp == XALU_MTHI) begin
                    hi_d = A;
                end else if (XaluOp == XALU_MTLO) begin
                    lo_d = A;
                end else if (Start && (is_mul_op(XaluOp) || is_div_op(XaluOp))) begin
                    op_d    = XaluOp;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = is_div_op(XaluOp) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (!div_zero) begin
                        {hi_d, lo_d} = result;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= XALU_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == StRun);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
